// File: rtl/ysyx_25040129_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_25040129_mem_arbiter
// Brief   : Two-master / one-slave AXI arbiter (ICACHE burst reads, LSU single beats)
// Revision: 1.0
// ============================================================================
module ysyx_25040129_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FIX_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  // M0: ICACHE read
  input  logic [ADDR_W-1:0]   i_m0_araddr,
  input  logic [7:0]          i_m0_arlen,
  input  logic [1:0]          i_m0_arburst,
  input  logic                i_m0_arvalid,
  output logic                o_m0_arready,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [1:0]          o_m0_rresp,
  output logic                o_m0_rlast,
  output logic                o_m0_rvalid,
  input  logic                i_m0_rready,
  // M1: LSU read/write
  input  logic [ADDR_W-1:0]   i_m1_araddr,
  input  logic                i_m1_arvalid,
  output logic                o_m1_arready,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic [1:0]          o_m1_rresp,
  output logic                o_m1_rvalid,
  input  logic                i_m1_rready,
  input  logic [ADDR_W-1:0]   i_m1_awaddr,
  input  logic                i_m1_awvalid,
  output logic                o_m1_awready,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  input  logic                i_m1_wvalid,
  output logic                o_m1_wready,
  output logic [1:0]          o_m1_bresp,
  output logic                o_m1_bvalid,
  input  logic                i_m1_bready,
  // Slave memory port
  output logic [ADDR_W-1:0]   o_s_araddr,
  output logic [7:0]          o_s_arlen,
  output logic [1:0]          o_s_arburst,
  output logic                o_s_arvalid,
  input  logic                i_s_arready,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  input  logic                i_s_rlast,
  input  logic                i_s_rvalid,
  output logic                o_s_rready,
  output logic [ADDR_W-1:0]   o_s_awaddr,
  output logic                o_s_awvalid,
  input  logic                i_s_awready,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  output logic                o_s_wlast,
  output logic                o_s_wvalid,
  input  logic                i_s_wready,
  input  logic [1:0]          i_s_bresp,
  input  logic                i_s_bvalid,
  output logic                o_s_bready
);

  localparam logic [1:0] c_BURST_INCR = 2'b01;
  localparam logic [7:0] c_LEN_SINGLE = 8'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_M0_AR = 3'd1,
    S_M0_R  = 3'd2,
    S_M1_AR = 3'd3,
    S_M1_R  = 3'd4,
    S_M1_WR = 3'd5,
    S_M1_B  = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_m1;   // 1: M1 held the most recent grant
  logic   r_aw_done;
  logic   r_w_done;

  logic w_m0_req;
  logic w_m1_req;
  logic w_pick_m1;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_done;

  assign w_m0_req  = i_m0_arvalid;
  assign w_m1_req  = i_m1_arvalid | i_m1_awvalid;
  assign w_pick_m1 = (FIX_PRIO != 0) ? w_m1_req
                                     : (w_m1_req & (!w_m0_req || !r_last_m1));

  // Handshakes are derived from inputs and flags only, keeping them free of output feedback
  assign w_aw_hs   = (r_state == S_M1_WR) & i_m1_awvalid & ~r_aw_done & i_s_awready;
  assign w_w_hs    = (r_state == S_M1_WR) & i_m1_wvalid  & ~r_w_done  & i_s_wready;
  assign w_wr_done = (r_state == S_M1_WR) & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last_m1 <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_M0_AR && i_m0_arvalid && i_s_arready) begin
        r_last_m1 <= 1'b0;
      end
      if (r_state == S_M1_AR && i_m1_arvalid && i_s_arready) begin
        r_last_m1 <= 1'b1;
      end
      if (w_wr_done) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_last_m1 <= 1'b1;
      end else begin
        r_aw_done <= r_aw_done | w_aw_hs;
        r_w_done  <= r_w_done  | w_w_hs;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    o_m0_arready = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = '0;
    o_m0_rlast   = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m1_arready = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = '0;
    o_m1_rvalid  = 1'b0;
    o_m1_awready = 1'b0;
    o_m1_wready  = 1'b0;
    o_m1_bresp   = '0;
    o_m1_bvalid  = 1'b0;
    o_s_araddr   = '0;
    o_s_arlen    = '0;
    o_s_arburst  = '0;
    o_s_arvalid  = 1'b0;
    o_s_rready   = 1'b0;
    o_s_awaddr   = '0;
    o_s_awvalid  = 1'b0;
    o_s_wdata    = '0;
    o_s_wstrb    = '0;
    o_s_wlast    = 1'b0;
    o_s_wvalid   = 1'b0;
    o_s_bready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_m0_req || w_m1_req) begin
          if (w_pick_m1) begin
            w_next = i_m1_awvalid ? S_M1_WR : S_M1_AR;
          end else begin
            w_next = S_M0_AR;
          end
        end
      end
      S_M0_AR: begin
        o_s_araddr   = i_m0_araddr;
        o_s_arlen    = i_m0_arlen;
        o_s_arburst  = i_m0_arburst;
        o_s_arvalid  = i_m0_arvalid;
        o_m0_arready = i_s_arready;
        if (i_m0_arvalid && i_s_arready) w_next = S_M0_R;
      end
      S_M0_R: begin
        o_m0_rdata  = i_s_rdata;
        o_m0_rresp  = i_s_rresp;
        o_m0_rlast  = i_s_rlast;
        o_m0_rvalid = i_s_rvalid;
        o_s_rready  = i_m0_rready;
        if (i_s_rvalid && i_m0_rready && i_s_rlast) w_next = S_IDLE;
      end
      S_M1_AR: begin
        o_s_araddr   = i_m1_araddr;
        o_s_arlen    = c_LEN_SINGLE;
        o_s_arburst  = c_BURST_INCR;
        o_s_arvalid  = i_m1_arvalid;
        o_m1_arready = i_s_arready;
        if (i_m1_arvalid && i_s_arready) w_next = S_M1_R;
      end
      S_M1_R: begin
        // The LSU always issues single beats, so the slave's rlast is not consulted
        o_m1_rdata  = i_s_rdata;
        o_m1_rresp  = i_s_rresp;
        o_m1_rvalid = i_s_rvalid;
        o_s_rready  = i_m1_rready;
        if (i_s_rvalid && i_m1_rready) w_next = S_IDLE;
      end
      S_M1_WR: begin
        o_s_awaddr   = i_m1_awaddr;
        o_s_awvalid  = i_m1_awvalid & ~r_aw_done;
        o_m1_awready = i_s_awready & ~r_aw_done;
        o_s_wdata    = i_m1_wdata;
        o_s_wstrb    = i_m1_wstrb;
        o_s_wlast    = 1'b1;
        o_s_wvalid   = i_m1_wvalid & ~r_w_done;
        o_m1_wready  = i_s_wready & ~r_w_done;
        if (w_wr_done) w_next = S_M1_B;
      end
      S_M1_B: begin
        o_m1_bresp  = i_s_bresp;
        o_m1_bvalid = i_s_bvalid;
        o_s_bready  = i_m1_bready;
        if (i_s_bvalid && i_m1_bready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_25040129_mem_arbiter
// Brief   : Directed vector table plus hand sequences for ties, skewed writes, reset
// Revision: 1.0
// ============================================================================
module tb_ysyx_25040129_mem_arbiter;

  logic        clk, rst_n;
  logic [31:0] m0_araddr;  logic [7:0] m0_arlen; logic [1:0] m0_arburst;
  logic        m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready;
  logic [31:0] m0_rdata;   logic [1:0] m0_rresp;
  logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [1:0]  m1_rresp, m1_bresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [3:0]  m1_wstrb, s_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [7:0]  s_arlen;    logic [1:0] s_arburst, s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

  int checks = 0;
  int errors = 0;

  ysyx_25040129_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIX_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_araddr(m0_araddr), .i_m0_arlen(m0_arlen), .i_m0_arburst(m0_arburst),
    .i_m0_arvalid(m0_arvalid), .o_m0_arready(m0_arready),
    .o_m0_rdata(m0_rdata), .o_m0_rresp(m0_rresp), .o_m0_rlast(m0_rlast),
    .o_m0_rvalid(m0_rvalid), .i_m0_rready(m0_rready),
    .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .o_m1_arready(m1_arready),
    .o_m1_rdata(m1_rdata), .o_m1_rresp(m1_rresp), .o_m1_rvalid(m1_rvalid),
    .i_m1_rready(m1_rready),
    .i_m1_awaddr(m1_awaddr), .i_m1_awvalid(m1_awvalid), .o_m1_awready(m1_awready),
    .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb), .i_m1_wvalid(m1_wvalid),
    .o_m1_wready(m1_wready),
    .o_m1_bresp(m1_bresp), .o_m1_bvalid(m1_bvalid), .i_m1_bready(m1_bready),
    .o_s_araddr(s_araddr), .o_s_arlen(s_arlen), .o_s_arburst(s_arburst),
    .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
    .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast),
    .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
    .o_s_awaddr(s_awaddr), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
    .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast),
    .o_s_wvalid(s_wvalid), .i_s_wready(s_wready),
    .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;      // 0: M0 read, 1: M1 read, 2: M1 write
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [7:0]  exp_arlen;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
             m0_arready, m1_arready, m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid}, 0);
  endtask

  // Waits (bounded) for s_arvalid (sel 0) or s_awvalid (sel 1)
  task automatic wait_hi(input string nm, input int sel);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ((sel == 0 && s_arvalid) || (sel == 1 && s_awvalid)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout actual=0 required=1", nm);
    end
  endtask

  task automatic ar_phase(input string nm, input int who, input logic [31:0] eaddr,
                          input logic [7:0] elen);
    wait_hi({nm, "_wait"}, 0);
    chk({nm, "_araddr"}, s_araddr, eaddr);
    chk({nm, "_arlen"}, s_arlen, elen);
    chk({nm, "_arburst"}, s_arburst, 2'b01);
    s_arready = 1'b1;
    #1;
    chk({nm, "_arready"}, {m0_arready, m1_arready}, (who == 0) ? 2'b10 : 2'b01);
    tick();
    s_arready = 1'b0;
    if (who == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
  endtask

  task automatic r_beat(input string nm, input int who, input logic [31:0] d,
                        input logic [1:0] rs, input logic last);
    s_rvalid = 1'b1; s_rdata = d; s_rresp = rs; s_rlast = last;
    #1;
    if (who == 0)
      chk({nm, "_m0r"}, {m0_rvalid, m0_rdata, m0_rresp, m0_rlast, m1_rvalid, s_rready},
          {1'b1, d, rs, last, 1'b0, 1'b1});
    else
      chk({nm, "_m1r"}, {m1_rvalid, m1_rdata, m1_rresp, m0_rvalid, s_rready},
          {1'b1, d, rs, 1'b0, 1'b1});
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  // lead = cycles by which awready precedes wready (0: same cycle)
  task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] st, input logic [1:0] rs, input int lead);
    m1_awaddr = a; m1_wdata = d; m1_wstrb = st;
    m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_bready = 1'b1;
    wait_hi({nm, "_wait"}, 1);
    chk({nm, "_aw"}, {s_awaddr, s_wdata, s_wstrb, s_wlast, s_wvalid, s_arvalid},
        {a, d, st, 1'b1, 1'b1, 1'b0});
    if (lead == 0) begin
      s_awready = 1'b1; s_wready = 1'b1;
      #1;
      chk({nm, "_rdy"}, {m1_awready, m1_wready}, 2'b11);
      tick();
      s_awready = 1'b0; s_wready = 1'b0;
    end else begin
      s_awready = 1'b1;
      #1;
      chk({nm, "_awrdy"}, {m1_awready, m1_wready}, 2'b10);
      tick();
      s_awready = 1'b0;
      for (int i = 0; i < lead - 1; i++) begin
        chk({nm, "_skew"}, {s_awvalid, s_wvalid}, 2'b01);
        tick();
      end
      s_wready = 1'b1;
      #1;
      chk({nm, "_wrdy"}, {s_awvalid, m1_wready}, 2'b01);
      tick();
      s_wready = 1'b0;
    end
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    chk({nm, "_preb"}, {s_awvalid, s_wvalid, m1_bvalid}, 3'b000);
    s_bvalid = 1'b1; s_bresp = rs;
    #1;
    chk({nm, "_b"}, {m1_bvalid, m1_bresp, s_bready}, {1'b1, rs, 1'b1});
    tick();
    s_bvalid = 1'b0;
    chk_idle({nm, "_idle"});
  endtask

  initial begin
    rst_n = 1'b0;
    m0_araddr = '0; m0_arlen = '0; m0_arburst = 2'b01; m0_arvalid = 1'b0; m0_rready = 1'b1;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
    m1_awaddr = '0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 1'b0;
    m1_bready = 1'b1;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;

    vecs[0] = '{0, 32'h8000_0010, 8'd3, 32'h1111_0000, 4'h0, 2'b00, 8'd3};
    vecs[1] = '{1, 32'h8000_0100, 8'd0, 32'hDEAD_BEEF, 4'h0, 2'b00, 8'd0};
    vecs[2] = '{2, 32'h8000_0200, 8'd0, 32'hA5A5_A5A5, 4'b0011, 2'b00, 8'd0};
    vecs[3] = '{1, 32'h8000_0104, 8'd0, 32'h1234_5678, 4'h0, 2'b10, 8'd0};
    vecs[4] = '{0, 32'h8000_0040, 8'd0, 32'hCAFE_0000, 4'h0, 2'b01, 8'd0};
    vecs[5] = '{2, 32'h8000_0300, 8'd0, 32'h0BAD_F00D, 4'b1100, 2'b11, 8'd0};

    #2;
    chk_idle("reset_state");
    chk("reset_data", {m0_rdata, m1_rdata, m0_rresp, m1_bresp, s_araddr, s_arlen}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_idle("idle_no_req");

    for (int v = 0; v < 6; v++) begin
      case (vecs[v].kind)
        0: begin
          m0_araddr = vecs[v].addr; m0_arlen = vecs[v].len; m0_arvalid = 1'b1;
          ar_phase($sformatf("v%0d", v), 0, vecs[v].addr, vecs[v].exp_arlen);
          for (int b = 0; b <= int'(vecs[v].len); b++)
            r_beat($sformatf("v%0d_b%0d", v, b), 0, vecs[v].data + b, vecs[v].resp,
                   b == int'(vecs[v].len));
        end
        1: begin
          m1_araddr = vecs[v].addr; m1_arvalid = 1'b1;
          ar_phase($sformatf("v%0d", v), 1, vecs[v].addr, vecs[v].exp_arlen);
          r_beat($sformatf("v%0d_b0", v), 1, vecs[v].data, vecs[v].resp, 1'b0);
        end
        default: wr($sformatf("v%0d", v), vecs[v].addr, vecs[v].data, vecs[v].strb,
                    vecs[v].resp, 0);
      endcase
      chk_idle($sformatf("v%0d_idle", v));
    end

    // Simultaneous reads alternate between masters; the last grant was M1 (write above)
    m0_araddr = 32'h8000_1000; m0_arlen = 8'd0; m0_arvalid = 1'b1;
    m1_araddr = 32'h8000_2000; m1_arvalid = 1'b1;
    ar_phase("tie1", 0, 32'h8000_1000, 8'd0);
    r_beat("tie1", 0, 32'h0000_0001, 2'b00, 1'b1);
    m0_arvalid = 1'b1;
    chk_idle("tie_gap");
    ar_phase("tie2", 1, 32'h8000_2000, 8'd0);
    r_beat("tie2", 1, 32'h0000_0002, 2'b00, 1'b0);
    ar_phase("tie3", 0, 32'h8000_1000, 8'd0);
    r_beat("tie3", 0, 32'h0000_0003, 2'b00, 1'b1);

    // Slave accepts AW two cycles before W
    wr("skew", 32'h8000_0400, 32'hA5A5_A5A5, 4'b0011, 2'b00, 2);

    // Write and read requested together: write is issued first
    m1_araddr = 32'h8000_0500; m1_arvalid = 1'b1;
    wr("wr_first", 32'h8000_0600, 32'h5555_AAAA, 4'hF, 2'b00, 1);
    ar_phase("rd_after", 1, 32'h8000_0500, 8'd0);
    r_beat("rd_after", 1, 32'h7777_8888, 2'b00, 1'b0);

    // Reset during the second beat of a burst
    m0_araddr = 32'h8000_0010; m0_arlen = 8'd3; m0_arvalid = 1'b1;
    ar_phase("rst_ar", 0, 32'h8000_0010, 8'd3);
    r_beat("rst_b0", 0, 32'hAAAA_0000, 2'b00, 1'b0);
    s_rvalid = 1'b1; s_rdata = 32'hAAAA_0001;
    #1;
    chk("rst_pre", m0_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    chk("rst_async_data", m0_rdata, 0);
    s_rvalid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    // After reset the last grant is M1 again, so M0 wins a tie
    m0_araddr = 32'h8000_0020; m0_arlen = 8'd1; m0_arvalid = 1'b1;
    m1_araddr = 32'h8000_0030; m1_arvalid = 1'b1;
    ar_phase("post_rst", 0, 32'h8000_0020, 8'd1);
    r_beat("post_rst_b0", 0, 32'hBBBB_0000, 2'b00, 1'b0);
    r_beat("post_rst_b1", 0, 32'hBBBB_0001, 2'b00, 1'b1);
    ar_phase("post_rst_m1", 1, 32'h8000_0030, 8'd0);
    r_beat("post_rst_m1", 1, 32'hCCCC_0000, 2'b00, 1'b0);
    chk_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
